// File: rtl/cp0_unit.sv
// cp0_unit: MIPS coprocessor 0 for the M stage.
// Holds SR, Cause, EPC and PRId, decides trap requests, and serves mfc0/mtc0/eret.
// Optional build macro CP0_TIMER_EN adds Count (reg 9), Compare (reg 11) and the
// timer-pending flag TI (Cause[30]), which is OR'd into HWInt[TIMER_LINE].
module cp0_unit #(
  parameter logic [31:0] PRID       = 32'h0000_7C07,
  parameter int unsigned TIMER_LINE = 7
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PCM,
  input  logic        BDM,
  input  logic [6:2]  ExcCodeM,
  input  logic [7:2]  HWInt,
  input  logic        EXLClr,
  output logic        Req,
  output logic [31:0] EPCOut,
  output logic [31:0] DOut
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;
  localparam logic [7:2] TIMER_MASK  = 6'(1 << (TIMER_LINE - 2));

  // SR fields
  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  // Cause fields
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  // EPC is word-aligned, so only bits [31:2] are stored
  logic [31:2] epc;

  logic        ti;
  logic [7:2]  hw_eff;
  logic        int_req;
  logic        exc_req;
  logic [31:2] epc_trap;
  logic        mtc0_ok;
  logic        unused_pcm;

`ifdef CP0_TIMER_EN
  logic [31:0] count;
  logic [31:0] compare;

  // Free-running counter, compare register and timer-pending flag
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count   <= 32'd0;
      compare <= 32'd0;
      ti      <= 1'b0;
    end else begin
      if (mtc0_ok && A2 == REG_COUNT) count <= DIn;
      else                            count <= count + 32'd1;
      if (mtc0_ok && A2 == REG_COMPARE) begin
        compare <= DIn;
        ti      <= 1'b0;
      end else if (count == compare && compare != 32'd0) begin
        ti <= 1'b1;
      end
    end
  end
`else
  assign ti = 1'b0;
`endif

  assign unused_pcm = ^PCM[1:0];

  // Trap request: interrupts and exceptions are both masked while EXL is set
  always_comb begin
    hw_eff   = HWInt | (ti ? TIMER_MASK : 6'b0);
    int_req  = sr_ie & ~sr_exl & (|(hw_eff & sr_im));
    exc_req  = (ExcCodeM != 5'd0) & ~sr_exl;
    Req      = int_req | exc_req;
    epc_trap = BDM ? (PCM[31:2] - 30'd1) : PCM[31:2];
    mtc0_ok  = WE & ~Req;
  end

  // Architectural state update: reset > trap > eret > mtc0
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sr_im     <= 6'd0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= 6'd0;
      cause_exc <= 5'd0;
      epc       <= 30'd0;
    end else begin
      cause_ip <= hw_eff;
      if (Req) begin
        sr_exl    <= 1'b1;
        cause_exc <= int_req ? 5'd0 : ExcCodeM;
        cause_bd  <= BDM;
        epc       <= epc_trap;
      end else begin
        if (WE && A2 == REG_SR) begin
          sr_im  <= DIn[15:10];
          sr_exl <= DIn[1];
          sr_ie  <= DIn[0];
        end
        if (EXLClr) sr_exl <= 1'b0;
        if (WE && A2 == REG_EPC) epc <= DIn[31:2];
      end
    end
  end

  // mfc0 read port returns pre-edge register values
  always_comb begin
    DOut = 32'd0;
    case (A1)
      REG_SR:    DOut = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
      REG_CAUSE: DOut = {cause_bd, ti, 14'd0, cause_ip, 3'd0, cause_exc, 2'd0};
      REG_EPC:   DOut = {epc, 2'b00};
      REG_PRID:  DOut = PRID;
`ifdef CP0_TIMER_EN
      REG_COUNT:   DOut = count;
      REG_COMPARE: DOut = compare;
`endif
      default:   DOut = 32'd0;
    endcase
  end

  assign EPCOut = {epc, 2'b00};

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 for the M stage of the 5-stage MIPS pipeline.
- Consumes the M-stage exception context (PC, branch-delay flag, ExcCode) from the E/M pipeline register, together with the external hardware interrupt lines.
- Decides whether the pipeline must trap and holds the SR, Cause, EPC and PRId registers.
- Serves mfc0/mtc0 accesses and eret.

Parameters:
- PRID, 32'h0000_7C07, constant value returned on reads of register 15.
- TIMER_LINE, 7, HWInt bit driven by the internal timer; used only with CP0_TIMER_EN.

Ports:
- Clk  in  1  clock, all state updates on the rising edge
- Reset  in  1  synchronous, active-high reset
- A1  in  5  CP0 register index for reads (mfc0)
- A2  in  5  CP0 register index for writes (mtc0)
- DIn  in  32  mtc0 write data
- WE  in  1  mtc0 write enable
- PCM  in  32  PC of the M-stage instruction
- BDM  in  1  M-stage instruction is in a branch-delay slot
- ExcCodeM  in  [6:2]  M-stage exception code; 0 means no exception
- HWInt  in  [7:2]  external interrupt lines, level-sensitive
- EXLClr  in  1  eret in M stage
- Req  out  1  trap request; flushes the pipeline and redirects the PC to the handler
- EPCOut  out  32  current EPC, used as the eret target
- DOut  out  32  read data for A1

Behaviour:
- SR (reg 12) implements only these fields: IM[15:10], EXL[1], IE[0]. All other SR bits read as 0.
- Cause (reg 13) implements only these fields: BD[31], IP[15:10], ExcCode[6:2]. All other Cause bits read as 0.
- EPC (reg 14) is always word-aligned; bits [1:0] read as 0.
- PRId (reg 15) reads PRID.
- Any other index reads 0, and writes to it are ignored.
- Combinational request logic:
  - IntReq = IE & ~EXL & |(HWInt & IM).
  - ExcReq = (ExcCodeM != 0) & ~EXL.
  - Req = IntReq | ExcReq.
- Priority on a rising edge, highest first:
  1. Reset: SR, Cause and EPC become 0. Req is therefore 0 in the following cycle.
  2. Req: EXL <= 1. Cause.ExcCode <= IntReq ? 0 : ExcCodeM, so an interrupt beats a synchronous exception in the same cycle. Cause.BD <= BDM. EPC <= BDM ? {PCM[31:2],2'b00} - 4 : {PCM[31:2],2'b00}. Any mtc0 in the same cycle is discarded.
  3. EXLClr: EXL <= 0. A same-cycle mtc0 to SR also applies, but EXLClr wins on EXL.
  4. WE:
     - A2 == 12 writes IM, EXL and IE from DIn.
     - A2 == 14 writes DIn[31:2], with the low bits forced to 0.
     - A2 == 13 and A2 == 15 are ignored (read-only from software).
- Cause.IP <= HWInt on every non-reset edge, regardless of Req, WE or EXL.
- Req is purely combinational and is valid in the same cycle as its inputs. Req = 0 whenever EXL = 1, so nested traps are impossible.
- DOut is combinational on A1 and returns the pre-edge value. An mtc0 and an mfc0 to the same register in the same cycle return the old value; upstream forwarding is not required.
- EPCOut equals the EPC register value.
- EPC subtraction wraps modulo 2^32; PCM = 0 with BDM = 1 yields 32'hFFFF_FFFC.
- Reset asserted in the same cycle as Req: reset wins, and no state is captured.

Optional Feature:
- Macro CP0_TIMER_EN.
- When defined, the following are added:
  - Count (reg 9): increments by 1 every non-reset cycle, wraps at 2^32, and is writable by mtc0, which takes precedence over the increment.
  - Compare (reg 11): writable by mtc0.
  - Timer-pending flag TI, readable at Cause[30]. TI sets on the edge where Count == Compare and Compare != 0, and clears on any mtc0 to Compare.
  - The effective HWInt[TIMER_LINE] is the external line OR'd with TI, for both IntReq and Cause.IP.
  - Reset clears Count, Compare and TI.
- When undefined: regs 9 and 11 read 0, writes to them are ignored, and Cause[30] reads 0.

Test Plan:
- Reset, then read regs 12/13/14/15 -> DOut = 0, 0, 0, 32'h0000_7C07; Req = 0.
- mtc0 SR = 32'h0000_FC01, HWInt = 6'b000100 -> Req = 1 in the same cycle. After the edge:
  - Cause.ExcCode = 0.
  - EXL = 1.
  - EPC = PCM (32'h0000_3010).
  - Req = 0.
- ExcCodeM = 5'd4 (AdEL), BDM = 1, PCM = 32'h0000_3008, IE = 0 -> Req = 1. After the edge:
  - EPC = 32'h0000_3004.
  - Cause = 32'h8000_0010.
- EXL = 1 with ExcCodeM = 5'd10 -> Req = 0. Assert EXLClr for one cycle -> EXL = 0 and Req = 1 in the next cycle.
- Same cycle: Req = 1 and mtc0 EPC = 32'h0000_4000 -> EPC takes the trap value, and the mtc0 is lost.
- With CP0_TIMER_EN: Compare = 10, Count = 0, SR = 32'h0000_8001 -> TI sets when Count reaches 10 (Cause[30] = 1) and Req = 1. Writing Compare clears TI.
